// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: decodes and resolves one branch per cycle, raises a mispredict
// flush, stalls intake for the flush window, and keeps a 2-bit direction predictor.
module branch_resolve_unit #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned PC_W      = 32,
   parameter int unsigned BHT_DEPTH = 16,
   parameter int unsigned FLUSH_CYC = 2
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              InValid,
   output logic              InReady,
   input  logic [3:0]        Op,
   input  logic [5:0]        Funct,
   input  logic [4:0]        RtSel,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [PC_W-1:0]   PC,
   input  logic [15:0]       Imm,
   input  logic [25:0]       JIdx,
   input  logic              PredTaken,
   output logic              OutValid,
   output logic              Taken,
   output logic [PC_W-1:0]   Target,
   output logic [PC_W-1:0]   Link,
   output logic              LinkWr,
   output logic              Flush,
   output logic [PC_W-1:0]   FlushPC,
   input  logic [PC_W-1:0]   FetchPC,
   output logic              PredOut
);

   localparam int unsigned IDX_W = $clog2(BHT_DEPTH);
   localparam int unsigned CNT_W = $clog2(FLUSH_CYC) + 1;

   typedef enum logic {S_RUN = 1'b0, S_DRAIN = 1'b1} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic                taken_q, taken_d;
   logic [PC_W-1:0]     target_q, target_d;
   logic [PC_W-1:0]     link_q, link_d;
   logic                link_wr_q, link_wr_d;
   logic                flush_q, flush_d;
   logic [PC_W-1:0]     flush_pc_q, flush_pc_d;
   logic                upd_valid_q, upd_valid_d;
   logic [IDX_W-1:0]    upd_idx_q, upd_idx_d;
   logic                upd_taken_q, upd_taken_d;
   logic [1:0]          bht_q [BHT_DEPTH];
   logic [1:0]          bht_d [BHT_DEPTH];

   logic                is_cond_c, is_jmp_c, is_jreg_c, br_taken_c, link_en_c, mispred_c;
   logic                a_neg_c, a_zero_c, a_eq_b_c, accept_c;
   logic [PC_W-1:0]     pc4_c, br_off_c, tgt_c;
   logic                unused_c;

   assign accept_c = InValid & in_ready_q;

   // Branch class decode, direction, target and mispredict detection
   always_comb begin
      is_cond_c  = 1'b0;
      is_jmp_c   = 1'b0;
      is_jreg_c  = 1'b0;
      br_taken_c = 1'b0;
      link_en_c  = 1'b0;
      a_neg_c    = A[DATA_W-1];
      a_zero_c   = (A == '0);
      a_eq_b_c   = (A == B);
      case (Op)
         4'd0: begin
            if (Funct == 6'b001000) begin
               is_jreg_c = 1'b1;
            end else if (Funct == 6'b001001) begin
               is_jreg_c = 1'b1;
               link_en_c = 1'b1;
            end
         end
         4'd1: begin is_cond_c = 1'b1; br_taken_c = a_eq_b_c; end
         4'd2: begin is_cond_c = 1'b1; br_taken_c = ~a_eq_b_c; end
         4'd3: is_jmp_c = 1'b1;
         4'd4: begin
            is_cond_c  = 1'b1;
            br_taken_c = RtSel[0] ? ~a_neg_c : a_neg_c;
            link_en_c  = RtSel[4];
         end
         4'd5: begin is_cond_c = 1'b1; br_taken_c = ~a_neg_c & ~a_zero_c; end
         4'd6: begin is_cond_c = 1'b1; br_taken_c = a_neg_c | a_zero_c; end
         4'd7: begin is_jmp_c = 1'b1; link_en_c = 1'b1; end
         default: ;
      endcase
      if (is_jmp_c || is_jreg_c) br_taken_c = 1'b1;

      pc4_c    = PC + PC_W'(4);
      br_off_c = {{(PC_W-18){Imm[15]}}, Imm, 2'b00};
      tgt_c    = pc4_c;
      if (is_cond_c) begin
         tgt_c = pc4_c + br_off_c;
      end else if (is_jmp_c) begin
         tgt_c[27:0] = {JIdx, 2'b00};
      end else if (is_jreg_c) begin
         tgt_c = PC_W'(A);
      end

      if (is_cond_c)      mispred_c = (br_taken_c != PredTaken);
      else if (is_jmp_c)  mispred_c = ~PredTaken;
      else                mispred_c = is_jreg_c;
   end

   // Next-state: result capture, predictor update, intake FSM
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      in_ready_d  = in_ready_q;
      out_valid_d = 1'b0;
      taken_d     = taken_q;
      target_d    = target_q;
      link_d      = link_q;
      link_wr_d   = link_wr_q;
      flush_d     = 1'b0;
      flush_pc_d  = flush_pc_q;
      upd_valid_d = 1'b0;
      upd_idx_d   = upd_idx_q;
      upd_taken_d = upd_taken_q;
      bht_d       = bht_q;

      // Counter update lands at the end of the result cycle so lookups see the old value
      if (upd_valid_q) begin
         if (upd_taken_q) begin
            if (bht_q[upd_idx_q] != 2'b11) bht_d[upd_idx_q] = bht_q[upd_idx_q] + 2'd1;
         end else begin
            if (bht_q[upd_idx_q] != 2'b00) bht_d[upd_idx_q] = bht_q[upd_idx_q] - 2'd1;
         end
      end

      if (accept_c) begin
         out_valid_d = 1'b1;
         taken_d     = br_taken_c;
         target_d    = tgt_c;
         link_d      = pc4_c;
         link_wr_d   = link_en_c;
         flush_d     = mispred_c;
         flush_pc_d  = br_taken_c ? tgt_c : pc4_c;
         upd_valid_d = is_cond_c;
         upd_idx_d   = PC[IDX_W+1:2];
         upd_taken_d = br_taken_c;
      end

      case (state_q)
         S_RUN: begin
            in_ready_d = 1'b1;
            if (accept_c && mispred_c) begin
               state_d    = S_DRAIN;
               cnt_d      = CNT_W'(FLUSH_CYC - 1);
               in_ready_d = 1'b0;
            end
         end
         S_DRAIN: begin
            in_ready_d = 1'b0;
            if (cnt_q == '0) begin
               state_d    = S_RUN;
               in_ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q     <= S_RUN;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         taken_q     <= 1'b0;
         target_q    <= '0;
         link_q      <= '0;
         link_wr_q   <= 1'b0;
         flush_q     <= 1'b0;
         flush_pc_q  <= '0;
         upd_valid_q <= 1'b0;
         upd_idx_q   <= '0;
         upd_taken_q <= 1'b0;
         for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         taken_q     <= taken_d;
         target_q    <= target_d;
         link_q      <= link_d;
         link_wr_q   <= link_wr_d;
         flush_q     <= flush_d;
         flush_pc_q  <= flush_pc_d;
         upd_valid_q <= upd_valid_d;
         upd_idx_q   <= upd_idx_d;
         upd_taken_q <= upd_taken_d;
         bht_q       <= bht_d;
      end
   end

   assign InReady  = in_ready_q;
   assign OutValid = out_valid_q;
   assign Taken    = taken_q;
   assign Target   = target_q;
   assign Link     = link_q;
   assign LinkWr   = link_wr_q;
   assign Flush    = flush_q;
   assign FlushPC  = flush_pc_q;
   assign PredOut  = bht_q[FetchPC[IDX_W+1:2]][1];

   assign unused_c = ^{FetchPC[PC_W-1:IDX_W+2], FetchPC[1:0], RtSel[3:1]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed scenarios plus randomized branches
// checked against a behavioural model of branch semantics and the predictor.
`timescale 1ns/1ps
module tb_branch_resolve_unit;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned PC_W      = 32;
   localparam int unsigned BHT_DEPTH = 16;
   localparam int unsigned FLUSH_CYC = 2;

   logic        Clk, Rst, InValid, InReady, PredTaken;
   logic [3:0]  Op;
   logic [5:0]  Funct;
   logic [4:0]  RtSel;
   logic [31:0] A, B, PC, FetchPC;
   logic [15:0] Imm;
   logic [25:0] JIdx;
   logic        OutValid, Taken, LinkWr, Flush, PredOut;
   logic [31:0] Target, Link, FlushPC;

   branch_resolve_unit #(
      .DATA_W(DATA_W), .PC_W(PC_W), .BHT_DEPTH(BHT_DEPTH), .FLUSH_CYC(FLUSH_CYC)
   ) dut (
      .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady), .Op(Op), .Funct(Funct),
      .RtSel(RtSel), .A(A), .B(B), .PC(PC), .Imm(Imm), .JIdx(JIdx), .PredTaken(PredTaken),
      .OutValid(OutValid), .Taken(Taken), .Target(Target), .Link(Link), .LinkWr(LinkWr),
      .Flush(Flush), .FlushPC(FlushPC), .FetchPC(FetchPC), .PredOut(PredOut)
   );

   typedef struct {
      logic [3:0]  op;
      logic [5:0]  funct;
      logic [4:0]  rt;
      logic [31:0] a, b, pc;
      logic [15:0] imm;
      logic [25:0] jidx;
      logic        pred;
   } br_t;

   typedef struct {
      logic        is_cond;
      logic        taken;
      logic [31:0] target;
      logic        chk_target;
      logic [31:0] link;
      logic        link_wr;
      logic        flush;
      logic [31:0] flush_pc;
      int unsigned cyc;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          failures = 0;
   int unsigned cyc = 0;
   int unsigned ready_from = 0;
   bit          in_reset = 1;
   int          model_bht[BHT_DEPTH];

   initial begin
      Clk = 0;
      forever #5 Clk = ~Clk;
   end

   always @(posedge Clk) cyc <= cyc + 1;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference semantics of one branch
   function automatic exp_t model(input br_t br);
      exp_t e;
      bit cond = 0, jmp = 0, jreg = 0;
      logic signed [31:0] sa, sb;
      logic [31:0] pc4;
      pc4 = br.pc + 32'd4;
      sa = br.a;
      sb = br.b;
      e.taken = 0; e.link = pc4; e.link_wr = 0; e.chk_target = 1; e.target = 0; e.cyc = 0;
      case (br.op)
         4'd0: if (br.funct == 6'd8) jreg = 1;
               else if (br.funct == 6'd9) begin jreg = 1; e.link_wr = 1; end
         4'd1: begin cond = 1; e.taken = (sa == sb); end
         4'd2: begin cond = 1; e.taken = (sa != sb); end
         4'd3: jmp = 1;
         4'd4: begin cond = 1; e.taken = br.rt[0] ? (sa >= 0) : (sa < 0); e.link_wr = br.rt[4]; end
         4'd5: begin cond = 1; e.taken = (sa > 0); end
         4'd6: begin cond = 1; e.taken = (sa <= 0); end
         4'd7: begin jmp = 1; e.link_wr = 1; end
         default: ;
      endcase
      if (jmp || jreg) e.taken = 1;
      if (cond)      e.target = pc4 + 32'($signed(br.imm)) * 32'd4;
      else if (jmp)  e.target = (pc4 & 32'hF000_0000) | (32'(br.jidx) * 32'd4);
      else if (jreg) e.target = br.a;
      else           e.chk_target = 0;
      if (cond)      e.flush = (e.taken != br.pred);
      else if (jmp)  e.flush = !br.pred;
      else           e.flush = jreg;
      e.flush_pc = e.taken ? e.target : pc4;
      e.is_cond  = cond;
      return e;
   endfunction

   function automatic br_t mk_br(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] pc, input logic [15:0] imm, input logic pred);
      br_t br;
      br.op = op; br.funct = 0; br.rt = 0; br.a = a; br.b = b; br.pc = pc;
      br.imm = imm; br.jidx = 0; br.pred = pred;
      return br;
   endfunction

   function automatic br_t rand_br();
      br_t br;
      br.op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
         0:       br.funct = 6'b001000;
         1:       br.funct = 6'b001001;
         default: br.funct = 6'($urandom);
      endcase
      br.rt = 5'($urandom);
      case ($urandom_range(0, 3))
         0:       br.a = 32'd0;
         1:       br.a = 32'h8000_0000 | $urandom;
         default: br.a = $urandom;
      endcase
      br.b    = ($urandom_range(0, 1) == 1) ? br.a : $urandom;
      br.pc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      br.imm  = 16'($urandom);
      br.jidx = 26'($urandom);
      br.pred = 1'($urandom);
      return br;
   endfunction

   function automatic bit exp_ready();
      return !in_reset && (cyc >= ready_from);
   endfunction

   // Present a branch until accepted; returns #1 into its result cycle
   task automatic send(input br_t br);
      exp_t e;
      bit done = 0;
      int idx;
      e = model(br);
      for (int k = 0; k < 40 && !done; k++) begin
         Op = br.op; Funct = br.funct; RtSel = br.rt; A = br.a; B = br.b; PC = br.pc;
         Imm = br.imm; JIdx = br.jidx; PredTaken = br.pred; InValid = 1;
         chk("in_ready", InReady, exp_ready());
         if (InReady) begin
            e.cyc = cyc + 1;
            sb_q.push_back(e);
            if (e.is_cond) begin
               idx = int'((br.pc >> 2) % BHT_DEPTH);
               if (e.taken) model_bht[idx] = (model_bht[idx] < 3) ? model_bht[idx] + 1 : 3;
               else         model_bht[idx] = (model_bht[idx] > 0) ? model_bht[idx] - 1 : 0;
            end
            if (e.flush) ready_from = cyc + 1 + FLUSH_CYC;
            done = 1;
         end
         @(posedge Clk); #1;
      end
      if (!done) chk("send_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      InValid = 0;
      repeat (n) begin
         chk("in_ready", InReady, exp_ready());
         @(posedge Clk); #1;
      end
   endtask

   task automatic check_pred_all(input string tag);
      InValid = 0;
      for (int i = 0; i < BHT_DEPTH; i++) begin
         FetchPC = ($urandom & 32'hFFFF_FFC3) | (32'(i) << 2);
         #1;
         chk(tag, PredOut, model_bht[i] >= 2);
      end
      @(posedge Clk); #1;
   endtask

   task automatic do_reset();
      Rst = 0; InValid = 0; in_reset = 1;
      #1;
      chk("rst_out_valid", OutValid, 0);
      chk("rst_taken", Taken, 0);
      chk("rst_target", Target, 0);
      chk("rst_link", Link, 0);
      chk("rst_link_wr", LinkWr, 0);
      chk("rst_flush", Flush, 0);
      chk("rst_flush_pc", FlushPC, 0);
      chk("rst_in_ready", InReady, 0);
      sb_q.delete();
      for (int i = 0; i < BHT_DEPTH; i++) model_bht[i] = 1;
      check_pred_all("rst_pred");
      @(posedge Clk); #1;
      Rst = 1; in_reset = 0; ready_from = cyc + 1;
   endtask

   // Monitor: pop and compare on every presented result
   always @(negedge Clk) begin : mon
      exp_t e;
      if (Rst) begin
         if (OutValid) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_out_valid", 1, 0);
            end else begin
               e = sb_q.pop_front();
               chk("out_cycle", cyc, e.cyc);
               chk("taken", Taken, e.taken);
               if (e.chk_target) chk("target", Target, e.target);
               chk("link", Link, e.link);
               chk("link_wr", LinkWr, e.link_wr);
               chk("flush", Flush, e.flush);
               chk("flush_pc", FlushPC, e.flush_pc);
            end
         end else begin
            chk("flush_idle", Flush, 0);
         end
      end
   end

   initial begin
      br_t br;
      bit  pre;
      Rst = 0; InValid = 0; Op = 0; Funct = 0; RtSel = 0; A = 0; B = 0; PC = 0;
      Imm = 0; JIdx = 0; PredTaken = 0; FetchPC = 0;
      @(posedge Clk); #1;
      do_reset();
      idle(2);

      send(mk_br(4'd1, 32'd5, 32'd5, 32'h100, 16'h0003, 1'b1));
      idle(2);

      // mispredicted bne, then a branch offered inside the stall window
      send(mk_br(4'd2, 32'd7, 32'd7, 32'h300, 16'h0010, 1'b1));
      send(mk_br(4'd1, 32'd1, 32'd2, 32'h304, 16'h0005, 1'b0));
      idle(FLUSH_CYC + 2);

      br = mk_br(4'd4, 32'h8000_0000, 32'd0, 32'h400, 16'h0008, 1'b0);
      br.rt = 5'b10001;
      send(br);
      idle(1);

      br = mk_br(4'd0, 32'h0040_0020, 32'd0, 32'h500, 16'h0000, 1'b0);
      br.funct = 6'b001000;
      send(br);
      br.pred = 1;
      send(br);
      idle(FLUSH_CYC + 2);

      br = mk_br(4'd7, 32'd0, 32'd0, 32'hFFFF_FFFC, 16'h0000, 1'b1);
      br.jidx = 26'h3AB_CDEF;
      send(br);
      send(mk_br(4'd1, 32'd3, 32'd3, 32'hFFFF_FFF8, 16'h8000, 1'b1));
      send(mk_br(4'd6, 32'hFFFF_FFFF, 32'd0, 32'h700, 16'hFFFF, 1'b1));
      send(mk_br(4'd5, 32'd0, 32'd0, 32'h704, 16'h0004, 1'b0));
      idle(FLUSH_CYC + 2);

      // predictor training from reset at one PC
      do_reset();
      FetchPC = 32'h200;
      idle(2);
      for (int k = 0; k < 4; k++) begin
         pre = (model_bht[0] >= 2);
         chk("pred_before", PredOut, pre);
         send(mk_br(4'd1, 32'd9, 32'd9, 32'h200, 16'h0001, pre));
         chk("pred_same_cycle", PredOut, pre);
         idle(1);
         chk("pred_after", PredOut, model_bht[0] >= 2);
         idle(FLUSH_CYC);
      end

      // reset while draining
      send(mk_br(4'd2, 32'd3, 32'd3, 32'h600, 16'h0001, 1'b1));
      idle(1);
      do_reset();
      idle(2);
      check_pred_all("pred_after_rst");

      repeat (400) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         FetchPC = $urandom;
         send(rand_br());
      end
      idle(FLUSH_CYC + 3);
      chk("sb_empty", sb_q.size(), 0);
      check_pred_all("pred_final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the operand width.
REQ-002 The block SHALL have parameter PC_W, default 32, giving the PC width (PC_W >= 28).
REQ-003 The block SHALL have parameter BHT_DEPTH, default 16, giving the number of predictor entries (power of 2, >= 2).
REQ-004 The block SHALL have parameter FLUSH_CYC, default 2, giving the post-flush stall length in cycles (>= 1).
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
- Clk  in  1  clock
- Rst  in  1  asynchronous active-low reset
REQ-006 The block SHALL have the following resolve ports.
- InValid  in  1  branch presented
- InReady  out  1  unit can accept
- Op  in  4  branch class
- Funct  in  6  R-type funct
- RtSel  in  5  REGIMM rt field
- A, B  in  DATA_W  compare operands
- PC  in  PC_W  branch instruction address
- Imm  in  16  signed word offset
- JIdx  in  26  jump index
- PredTaken  in  1  fetch-time prediction carried with the branch
REQ-007 The block SHALL have the following result ports.
- OutValid  out  1  result valid
- Taken  out  1  resolved direction
- Target  out  PC_W  taken target
- Link  out  PC_W  link address
- LinkWr  out  1  link write required
- Flush  out  1  mispredict pulse
- FlushPC  out  PC_W  redirect address
REQ-008 The block SHALL have the following lookup ports.
- FetchPC  in  PC_W  fetch address
- PredOut  out  1  predicted taken

Function
REQ-009 An accept SHALL occur on a rising Clk where InValid=1 and InReady=1; InValid while InReady=0 SHALL be ignored.
REQ-010 Results SHALL be registered: OutValid=1 for exactly one cycle, the cycle after the accept; otherwise OutValid=0, and the other result outputs hold their last values.
REQ-011 Op decode SHALL be as follows; any other Op SHALL give Taken=0, Flush=0 and no predictor update.
- 0: jr if Funct=001000, jalr if Funct=001001, else no branch
- 1: beq, taken when A==B
- 2: bne, taken when A!=B
- 3: j
- 4: REGIMM; RtSel[0]=1 is bgez (~A[MSB]), RtSel[0]=0 is bltz (A[MSB]); RtSel[4]=1 is the link variant
- 5: bgtz, taken when ~A[MSB] and A!=0
- 6: blez, taken when A[MSB] or A==0
- 7: jal
REQ-012 Comparisons SHALL be signed two's complement on DATA_W bits.
REQ-013 Target SHALL be computed per class.
- conditional: PC+4+(sext(Imm)<<2)
- j/jal: {(PC+4)[PC_W-1:28], JIdx, 2'b00}
- jr/jalr: A[PC_W-1:0]
- All additions SHALL wrap modulo 2^PC_W.
REQ-014 Link SHALL equal PC+4 (wrapping); LinkWr=1 only for jal, jalr, bltzal and bgezal; for a link branch LinkWr SHALL be 1 whether or not the branch is taken.
REQ-015 Flush SHALL be raised under the following conditions, otherwise 0.
- conditional: Taken != PredTaken
- j/jal: PredTaken=0
- jr/jalr: always
REQ-016 FlushPC SHALL be Target when Taken=1, else PC+4.
REQ-017 The predictor SHALL hold BHT_DEPTH 2-bit saturating counters indexed by PC[log2(BHT_DEPTH)+1:2], each reset to 01.
REQ-018 At the result cycle of a conditional branch only, the indexed counter SHALL increment if Taken (saturating at 11) or decrement if not (saturating at 00).
REQ-019 PredOut SHALL be combinational: counter[FetchPC index][1]. When a lookup and an update hit the same entry in the same cycle, PredOut SHALL return the pre-update value.
REQ-020 The FSM SHALL have states RUN and DRAIN.
- RUN: InReady=1.
- A result cycle with Flush=1 SHALL enter DRAIN.
- DRAIN: InReady=0 for exactly FLUSH_CYC cycles, counting the Flush cycle as the first, then return to RUN.
- Back-to-back accepts with no flush SHALL sustain one branch per cycle.
REQ-021 An accept in the cycle before a flush result SHALL be discarded: no OutValid, no Flush and no predictor update for it.

Reset
REQ-022 While Rst=0 the following SHALL hold.
- All result outputs SHALL be 0.
- InReady SHALL be 0.
- The state SHALL be RUN, with the drain counter at 0.
- All counters SHALL be 01.
REQ-023 Rst asserted mid-DRAIN or mid-result SHALL take effect immediately, with no Flush pulse afterwards; InReady=1 SHALL hold from the first Clk edge after release.

Verification
REQ-024 The bench SHALL cover the following directed scenarios.
- beq, A=B=5, PC=0x100, Imm=0x0003, PredTaken=1 -> next cycle OutValid=1, Taken=1, Target=0x110, Flush=0.
- bne, A=B, PredTaken=1, FLUSH_CYC=2 -> Flush=1, FlushPC=PC+4; InReady=0 for 2 cycles; a second branch presented during that window is ignored.
- bgezal, A=0x80000000 -> Taken=0, LinkWr=1, Link=PC+4.
- Taken beq at the same PC 4 times from reset -> PredOut for that PC goes 0,1,1,1,1 (01->10->11->11).
- jr, A=0x0040_0020 -> Taken=1, Target=0x0040_0020, Flush=1 regardless of PredTaken.
- Rst low during DRAIN -> Flush=0, InReady=1 after release, and all PredOut=0.
